// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate execute unit.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2,
        SH_ROL = 2'd3
    } shift_op_e;

    localparam int SHIFT_W = 32;

endpackage

// File: rtl/slc.sv
// Cyclic left shifter: r is a rotated left by b, built as a log-depth
// chain of power-of-two rotate stages.
module slc #(
    parameter int N = 32
) (
    output logic [N-1:0]         r,
    input  logic [N-1:0]         a,
    input  logic [$clog2(N)-1:0] b
);
    localparam int K = $clog2(N);

    logic [N-1:0] t;

    // NOTE: combinational blocks use blocking '=' so each stage sees the
    // previous stage's value within the same evaluation; clocked blocks use '<='.
    always_comb begin
        t = a;
        for (int s = 0; s < K; s++) begin
            if (b[s]) begin
                t = (t << (1 << s)) | (t >> (N - (1 << s)));
            end
        end
        r = t;
    end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage pipelined SLL/SRL/SRA/ROL unit. S1 precomputes the rotate amount
// and mask; S2 rotates through slc and applies the mask and sign fill.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int N = SHIFT_W,
    parameter int K = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [K-1:0] in_b,
    input  logic [1:0]   in_op,
    input  logic [4:0]   in_rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_r,
    output logic [4:0]   out_rd
);

    logic         v1;
    logic         v2;
    logic         r1;
    logic         r2;

    logic [N-1:0] s1_a;
    logic [N-1:0] s1_mask;
    logic [K-1:0] s1_ra;
    logic [4:0]   s1_rd;
    shift_op_e    s1_op;

    shift_op_e    in_op_e;
    logic [K-1:0] ra_next;
    logic [N-1:0] mask_next;

    logic [N-1:0] rot;
    logic [N-1:0] r_next;

    // A stage may load when it is empty or the stage after it is draining.
    always_comb begin
        r2        = !v2 || out_ready;
        r1        = !v1 || r2;
        in_ready  = r1;
        out_valid = v2;
    end

    // Right shifts become a left rotate by (N - b) mod N, which wraps
    // naturally in K bits; the mask then clears the wrapped-in bits.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        in_op_e   = shift_op_e'(in_op);
        ra_next   = in_b;
        mask_next = '1;
        case (in_op_e)
            SH_SLL: begin
                mask_next = {N{1'b1}} << in_b;
            end
            SH_SRL, SH_SRA: begin
                ra_next   = K'(0) - in_b;
                mask_next = {N{1'b1}} >> in_b;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are reset as well as valids so the result port
        // reads zero while the pipeline is held in reset.
        if (rst) begin
            v1      <= 1'b0;
            s1_a    <= '0;
            s1_mask <= '0;
            s1_ra   <= '0;
            s1_rd   <= '0;
            s1_op   <= SH_SLL;
        end else if (r1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_a    <= in_a;
                s1_mask <= mask_next;
                s1_ra   <= ra_next;
                s1_rd   <= in_rd;
                s1_op   <= in_op_e;
            end
        end
    end

    slc #(.N(N)) u_slc (
        .r (rot),
        .a (s1_a),
        .b (s1_ra)
    );

    // SRA fills the bits cleared by the mask with copies of the sign bit.
    always_comb begin
        r_next = rot & s1_mask;
        if (s1_op == SH_SRA && s1_a[N-1]) begin
            r_next = r_next | ~s1_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            out_r  <= '0;
            out_rd <= '0;
        end else if (r2) begin
            v2 <= v1;
            if (v1) begin
                out_r  <= r_next;
                out_rd <= s1_rd;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe: single ops, streaming,
// backpressure and asynchronous reset with the pipeline full.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int N = 32;
    localparam int K = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [K-1:0] in_b;
    logic [1:0]   in_op;
    logic [4:0]   in_rd;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_r;
    logic [4:0]   out_rd;

    int checks   = 0;
    int failures = 0;

    shift_pipe #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_rd    (out_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [4:0] b,
                         input logic [1:0] op, input logic [4:0] rd);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_rd    = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_op    = '0;
        in_rd    = '0;
    endtask

    // One isolated op on an empty pipeline with out_ready high.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [4:0] b,
                           input logic [1:0] op, input logic [4:0] rd, input logic [31:0] exp);
        drive(a, b, op, rd);
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        idle();
        check({tag, "_not_yet"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_r"}, out_r, exp);
        check({tag, "_rd"}, out_rd, rd);
        tick();
        check({tag, "_drained"}, out_valid, 0);
    endtask

    logic [31:0] st_a   [8] = '{32'h0000000F, 32'h0000F000, 32'h80000000, 32'h12345678,
                                32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h000000FF};
    logic [4:0]  st_b   [8] = '{5'd4, 5'd8, 5'd1, 5'd4, 5'd16, 5'd16, 5'd16, 5'd28};
    logic [1:0]  st_op  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] st_exp [8] = '{32'h000000F0, 32'h000000F0, 32'hC0000000, 32'h23456781,
                                32'hA5A50000, 32'h0000A5A5, 32'hFFFFA5A5, 32'hF000000F};

    initial begin
        idle();
        out_ready = 1'b1;

        // Reset state
        #1 rst = 1'b1;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_rd", out_rd, 0);
        tick();
        tick();
        rst = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        // Single-op directed vectors
        run_one("sll_1_5",     32'h00000001, 5'd5,  SH_SLL, 5'd1,  32'h00000020);
        run_one("sll_ff_31",   32'hFFFFFFFF, 5'd31, SH_SLL, 5'd2,  32'h80000000);
        run_one("srl_msb_31",  32'h80000000, 5'd31, SH_SRL, 5'd3,  32'h00000001);
        run_one("sra_neg_4",   32'hF0000000, 5'd4,  SH_SRA, 5'd4,  32'hFF000000);
        run_one("sra_pos_4",   32'h70000000, 5'd4,  SH_SRA, 5'd5,  32'h07000000);
        run_one("srl_b0",      32'h80000000, 5'd0,  SH_SRL, 5'd6,  32'h80000000);
        run_one("rol_1",       32'h80000001, 5'd1,  SH_ROL, 5'd7,  32'h00000003);
        run_one("rol_31",      32'h80000001, 5'd31, SH_ROL, 5'd8,  32'hC0000000);
        run_one("sra_neg_31",  32'h80000000, 5'd31, SH_SRA, 5'd9,  32'hFFFFFFFF);
        run_one("sll_b0",      32'h12345678, 5'd0,  SH_SLL, 5'd10, 32'h12345678);
        run_one("sra_b0",      32'h80000000, 5'd0,  SH_SRA, 5'd11, 32'h80000000);
        run_one("rol_b0",      32'hDEADBEEF, 5'd0,  SH_ROL, 5'd12, 32'hDEADBEEF);

        // Streaming: 8 back-to-back ops, one result per cycle in order
        for (int i = 0; i < 8; i++) begin
            drive(st_a[i], st_b[i], st_op[i], 5'(16 + i));
            check("stream_in_ready", in_ready, 1);
            tick();
            if (i > 0) begin
                check("stream_valid", out_valid, 1);
                check("stream_r", out_r, st_exp[i-1]);
                check("stream_rd", out_rd, 32'(15 + i));
            end
        end
        idle();
        tick();
        check("stream_last_valid", out_valid, 1);
        check("stream_last_r", out_r, st_exp[7]);
        check("stream_last_rd", out_rd, 23);
        tick();
        check("stream_empty", out_valid, 0);

        // Backpressure: out_ready low for 4 edges
        out_ready = 1'b0;
        drive(32'h00000003, 5'd1, SH_SLL, 5'd24);
        check("bp_accept0_ready", in_ready, 1);
        tick();
        check("bp_s1_only_valid", out_valid, 0);
        drive(32'h0000000C, 5'd2, SH_SRL, 5'd25);
        check("bp_accept1_ready", in_ready, 1);
        tick();
        drive(32'hFFFFFF00, 5'd8, SH_SRA, 5'd26);
        check("bp_full_in_ready", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_stall_in_ready", in_ready, 0);
            check("bp_stall_valid", out_valid, 1);
            check("bp_stall_r", out_r, 32'h00000006);
            check("bp_stall_rd", out_rd, 24);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        tick();
        check("bp_out1_r", out_r, 32'h00000003);
        check("bp_out1_rd", out_rd, 25);
        drive(32'hF0000000, 5'd4, SH_ROL, 5'd27);
        tick();
        idle();
        check("bp_out2_r", out_r, 32'hFFFFFFFF);
        check("bp_out2_rd", out_rd, 26);
        tick();
        check("bp_out3_valid", out_valid, 1);
        check("bp_out3_r", out_r, 32'h0000000F);
        check("bp_out3_rd", out_rd, 27);
        tick();
        check("bp_drained", out_valid, 0);

        // Asynchronous reset with both stages full, between clock edges
        out_ready = 1'b0;
        drive(32'h00000001, 5'd3, SH_SLL, 5'd28);
        tick();
        drive(32'h00000002, 5'd1, SH_SLL, 5'd29);
        tick();
        idle();
        check("prerst_full_in_ready", in_ready, 0);
        check("prerst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_r", out_r, 0);
        check("arst_out_rd", out_rd, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check("postrst_in_ready", in_ready, 1);
        check("postrst_valid", out_valid, 0);
        tick();
        check("postrst_still_empty", out_valid, 0);
        run_one("postrst_op", 32'h0000FFFF, 5'd4, SH_SRL, 5'd30, 32'h00000FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
